alu_issue_writeback: RTL and testbench
======================================

Name: alu_issue_writeback

Overview:
- Producer and consumer wrapped around the combinational ALU.
- Accepts R-type instructions with register operands over a valid/ready handshake.
- Decodes the funct field into the ALU operation code and drives operandA/operandB from a registered execute stage.
- Captures result/carry/zero/sign into a registered writeback stage with its own valid/ready handshake toward the register file.

Parameters:
- ICNT_W, 32, width of wrapping issued-instruction counter
- ECNT_W, 16, width of saturating illegal-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous active-high reset
- in_valid  input  1  instruction/operands valid
- in_ready  output  1  stage can accept this cycle
- instr  input  32  MIPS instruction word
- rs_data  input  32  value of register rs
- rt_data  input  32  value of register rt
- alu_operation  output  6  to ALU operation
- alu_operandA  output  32  to ALU operandA
- alu_operandB  output  32  to ALU operandB
- alu_result  input  32  from ALU result_out
- alu_carry  input  1  from ALU carry
- alu_zero  input  1  from ALU zero
- alu_sign  input  1  from ALU sign
- wb_valid  output  1  writeback entry valid
- wb_ready  input  1  register file accepts entry
- wb_we  output  1  write enable (legal and rd != 0)
- wb_rd  output  5  destination register
- wb_data  output  32  result to write
- wb_flags  output  3  {carry, zero, sign}
- wb_illegal  output  1  entry came from illegal instruction
- instr_count  output  ICNT_W  accepted instructions, wraps
- illegal_count  output  ECNT_W  illegal instructions, saturates at all-ones

Behaviour:
- Reset: all outputs are 0, including in_ready, both valid flags, both counters, and the E/W registers.
- in_ready goes to 1 on the first cycle after reset deasserts.
- Pipeline has two registers: E (execute) and W (writeback).
- ALU ports are driven only from E registers. The ALU is combinational between E and W.
- Advance rules:
  - w_adv = !wb_valid | wb_ready
  - e_adv = e_valid & w_adv
  - in_ready = !e_valid | w_adv
  - Accept = in_valid & in_ready.
- Full throughput: one instruction per cycle when wb_ready is held high.
- Latency: instruction accepted at edge N is on the ALU ports after N, and wb_valid is asserted after edge N+1.
- Stall: W is held while wb_valid & !wb_ready. E and the ALU ports are then held stable, and in_ready=0 if E is full.
- Bubble: when E advances with no new accept, e_valid clears. When W advances with E empty, wb_valid clears.
- Decode (instr[31:26] must be 000000, otherwise illegal):
  - funct 100000..100111, 101010, 101011: op=funct, A=rs_data, B=rt_data
  - funct 000000/000010/000011 (sll/srl/sra): op=funct, A=rt_data, B={27'b0, instr[10:6]}
  - funct 000100/000110/000111 (sllv/srlv/srav): op=000000/000010/000011 respectively, A=rt_data, B={27'b0, rs_data[4:0]}
  - any other funct, or nonzero opcode: illegal
- Illegal entries:
  - E is loaded with op=000000, A=0, B=0.
  - W is loaded with wb_illegal=1, wb_we=0, wb_data=0, wb_flags=0.
  - The entry still flows through the pipeline and must be accepted on wb_ready.
- rd = instr[15:11] for all legal entries.
- wb_we=0 when rd==0, but wb_data still carries the ALU result.
- Counters update on accept only (not on writeback):
  - instr_count += 1, wrapping.
  - illegal_count += 1 when illegal, unless already all-ones.
- Simultaneous events:
  - When E advances and a new instruction is accepted in the same cycle, E is overwritten without a bubble.
  - When wb_ready and w_adv coincide with E empty, wb_valid drops the next cycle.
- Reset mid-operation: all in-flight E/W entries are discarded, wb_valid=0 the next cycle, and counters clear. Data registers need not clear except where they drive outputs.

Test Plan:
- Single add: instr=0x00221820 (add $3,$1,$2), rs=5, rt=7, wb_ready=1.
  - After one edge: alu_operation=100000, A=5, B=7.
  - After two edges: wb_valid=1, wb_rd=3, wb_data=12, wb_we=1, wb_flags=000.
- Shift decode:
  - sll $4,$2,24 with rt=1 -> B=24, wb_data=0x01000000.
  - srav with rs=0x26, rt=0x80000000 -> op=000011, B=6, wb_data=0xFE000000.
- Back-pressure: stream 4 back-to-back subs, hold wb_ready=0 for 3 cycles after the first wb_valid.
  - in_ready drops once E is full; W and the ALU ports stay stable.
  - All 4 results arrive in order, none lost or duplicated.
  - instr_count=4.
- Illegal: opcode 001000 and then funct 011011.
  - Each yields wb_illegal=1, wb_we=0, wb_data=0.
  - illegal_count=2.
  - Following legal slt rs=-1, rt=1 gives wb_data=1.
- rd=0: or with rs=0xF0F0F0F0, rt=0x0F0F0F0F, rd=0 -> wb_data=0xFFFFFFFF, wb_we=0, wb_flags sign=1.
- Reset mid-stream: assert reset for 1 cycle with E and W full.
  - Next cycle: wb_valid=0, in_ready=0, counters=0.
  - One cycle later: in_ready=1, and a fresh add completes normally.

Source files
------------

// File: rtl/alu_issue_writeback.sv
// alu_issue_writeback
// Issue/writeback wrapper around an external combinational ALU.
//   - Input side: R-type instruction plus rs/rt values over in_valid/in_ready.
//   - E stage: decoded operation and operands, driving alu_operation/A/B.
//   - W stage: captures ALU result and flags, offered on wb_valid/wb_ready.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          instruction handshake; instr, rs_data, rt_data
//   alu_operation/A/B          registered ALU inputs (E stage)
//   alu_result/carry/zero/sign combinational ALU outputs
//   wb_valid/wb_ready          writeback handshake; wb_we, wb_rd, wb_data,
//                              wb_flags {carry,zero,sign}, wb_illegal
//   instr_count                accepted instructions (wraps)
//   illegal_count              accepted illegal instructions (saturates)
module alu_issue_writeback #(
  parameter int ICNT_W = 32,
  parameter int ECNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  output logic [5:0]        alu_operation,
  output logic [31:0]       alu_operandA,
  output logic [31:0]       alu_operandB,
  input  logic [31:0]       alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_sign,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic [2:0]        wb_flags,
  output logic              wb_illegal,
  output logic [ICNT_W-1:0] instr_count,
  output logic [ECNT_W-1:0] illegal_count
);

  localparam logic [ECNT_W-1:0] ECNT_MAX = {ECNT_W{1'b1}};
  localparam logic [ICNT_W-1:0] ICNT_ONE = {{(ICNT_W-1){1'b0}}, 1'b1};
  localparam logic [ECNT_W-1:0] ECNT_ONE = {{(ECNT_W-1){1'b0}}, 1'b1};

  // ready_en holds in_ready low during reset and for the first cycle after.
  logic        ready_en;
  logic        e_valid;
  logic        e_illegal;
  logic [4:0]  e_rd;

  logic        w_adv;
  logic        e_adv;
  logic        accept;

  logic        dec_illegal;
  logic [5:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;

  // Register specifiers are not needed: operand values arrive on rs/rt_data.
  logic unused_fields;
  assign unused_fields = ^instr[25:16];

  assign w_adv    = !wb_valid | wb_ready;
  assign e_adv    = e_valid & w_adv;
  assign in_ready = ready_en & (!e_valid | w_adv);
  assign accept   = in_valid & in_ready;

  // Decode funct into ALU op and operand selection; anything else is illegal.
  always_comb begin
    dec_illegal = 1'b1;
    dec_op      = 6'b000000;
    dec_a       = 32'd0;
    dec_b       = 32'd0;
    if (instr[31:26] == 6'b000000) begin
      case (instr[5:0])
        6'b100000, 6'b100001, 6'b100010, 6'b100011,
        6'b100100, 6'b100101, 6'b100110, 6'b100111,
        6'b101010, 6'b101011: begin
          dec_illegal = 1'b0;
          dec_op      = instr[5:0];
          dec_a       = rs_data;
          dec_b       = rt_data;
        end
        6'b000000, 6'b000010, 6'b000011: begin
          dec_illegal = 1'b0;
          dec_op      = instr[5:0];
          dec_a       = rt_data;
          dec_b       = {27'd0, instr[10:6]};
        end
        // Variable shifts reuse the immediate-shift ALU codes: low two funct
        // bits map 100->00, 110->10, 111->11.
        6'b000100, 6'b000110, 6'b000111: begin
          dec_illegal = 1'b0;
          dec_op      = {4'b0000, instr[1:0]};
          dec_a       = rt_data;
          dec_b       = {27'd0, rs_data[4:0]};
        end
        default: begin
          dec_illegal = 1'b1;
        end
      endcase
    end else begin
      dec_illegal = 1'b1;
    end
  end

  // E and W pipeline registers with valid/ready advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en      <= 1'b0;
      e_valid       <= 1'b0;
      e_illegal     <= 1'b0;
      e_rd          <= 5'd0;
      alu_operation <= 6'd0;
      alu_operandA  <= 32'd0;
      alu_operandB  <= 32'd0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= 32'd0;
      wb_flags      <= 3'd0;
      wb_illegal    <= 1'b0;
    end else begin
      ready_en <= 1'b1;

      // A new accept overwrites E directly, so no bubble on back-to-back.
      if (accept) begin
        e_valid       <= 1'b1;
        e_illegal     <= dec_illegal;
        e_rd          <= dec_illegal ? 5'd0 : instr[15:11];
        alu_operation <= dec_op;
        alu_operandA  <= dec_a;
        alu_operandB  <= dec_b;
      end else if (e_adv) begin
        e_valid <= 1'b0;
      end

      if (w_adv) begin
        wb_valid <= e_valid;
        if (e_valid) begin
          wb_illegal <= e_illegal;
          wb_rd      <= e_rd;
          wb_we      <= !e_illegal && (e_rd != 5'd0);
          wb_data    <= e_illegal ? 32'd0 : alu_result;
          wb_flags   <= e_illegal ? 3'd0 : {alu_carry, alu_zero, alu_sign};
        end
      end
    end
  end

  // Statistics counters, stepped on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count   <= {ICNT_W{1'b0}};
      illegal_count <= {ECNT_W{1'b0}};
    end else if (accept) begin
      instr_count <= instr_count + ICNT_ONE;
      if (dec_illegal && (illegal_count != ECNT_MAX)) begin
        illegal_count <= illegal_count + ECNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_writeback.sv
module tb_alu_issue_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [5:0]  alu_operation;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_sign;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  wb_flags;
  logic        wb_illegal;
  logic [31:0] instr_count;
  logic [15:0] illegal_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_icnt = 0;

  always #5 clk = ~clk;

  alu_issue_writeback #(.ICNT_W(32), .ECNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_operation(alu_operation), .alu_operandA(alu_operandA),
    .alu_operandB(alu_operandB),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_sign(alu_sign),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_flags(wb_flags),
    .wb_illegal(wb_illegal),
    .instr_count(instr_count), .illegal_count(illegal_count)
  );

  // Behavioural stand-in for the external combinational ALU.
  always_comb begin
    logic [32:0] sum;
    sum       = 33'd0;
    alu_carry = 1'b0;
    case (alu_operation)
      6'b100000, 6'b100001: begin
        sum        = {1'b0, alu_operandA} + {1'b0, alu_operandB};
        alu_result = sum[31:0];
        alu_carry  = sum[32];
      end
      6'b100010, 6'b100011: begin
        alu_result = alu_operandA - alu_operandB;
        alu_carry  = (alu_operandA < alu_operandB);
      end
      6'b100100: alu_result = alu_operandA & alu_operandB;
      6'b100101: alu_result = alu_operandA | alu_operandB;
      6'b100110: alu_result = alu_operandA ^ alu_operandB;
      6'b100111: alu_result = ~(alu_operandA | alu_operandB);
      6'b101010: alu_result = {31'd0, $signed(alu_operandA) < $signed(alu_operandB)};
      6'b101011: alu_result = {31'd0, alu_operandA < alu_operandB};
      6'b000000: alu_result = alu_operandA << alu_operandB[4:0];
      6'b000010: alu_result = alu_operandA >> alu_operandB[4:0];
      6'b000011: alu_result = $unsigned($signed(alu_operandA) >>> alu_operandB[4:0]);
      default:   alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
    alu_sign = alu_result[31];
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; instr = 32'd0; rs_data = 32'd0;
    rt_data = 32'd0; wb_ready = 1'b1;
    step(); step();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    vectors++; if (instr_count !== 32'd0 || illegal_count !== 16'd0) begin miscompares++; $display("FAIL reset_counts: got %0d/%0d want 0/0", instr_count, illegal_count); end
    vectors++; if ({alu_operation, alu_operandA, alu_operandB} !== 70'd0) begin miscompares++; $display("FAIL reset_alu_ports: got %h %h %h want 0", alu_operation, alu_operandA, alu_operandB); end
    vectors++; if ({wb_we, wb_rd, wb_data, wb_flags, wb_illegal} !== 42'd0) begin miscompares++; $display("FAIL reset_w_regs: got %h want 0", wb_data); end
    reset = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_release_ready: got %b want 0", in_ready); end
    step();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b want 1", in_ready); end
  endtask

  task automatic test_single_add();
    in_valid = 1'b1; instr = 32'h00221820; rs_data = 32'd5; rt_data = 32'd7; wb_ready = 1'b1;
    step();
    in_valid = 1'b0; exp_icnt++;
    vectors++; if (alu_operation !== 6'b100000 || alu_operandA !== 32'd5 || alu_operandB !== 32'd7) begin miscompares++; $display("FAIL add_alu_ports: got %b %0d %0d want 100000 5 7", alu_operation, alu_operandA, alu_operandB); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL add_latency: wb_valid got %b want 0", wb_valid); end
    step();
    vectors++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'd12 || wb_we !== 1'b1) begin miscompares++; $display("FAIL add_wb: got v%b rd%0d d%0d we%b want v1 rd3 d12 we1", wb_valid, wb_rd, wb_data, wb_we); end
    vectors++; if (wb_flags !== 3'b000 || wb_illegal !== 1'b0) begin miscompares++; $display("FAIL add_flags: got %b ill %b want 000 0", wb_flags, wb_illegal); end
    step();
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL add_bubble: wb_valid got %b want 0", wb_valid); end
    vectors++; if (instr_count !== exp_icnt) begin miscompares++; $display("FAIL add_count: got %0d want %0d", instr_count, exp_icnt); end
  endtask

  task automatic test_shift();
    in_valid = 1'b1; instr = rtype(5'd0, 5'd2, 5'd4, 5'd24, 6'b000000);
    rs_data = 32'h12345678; rt_data = 32'd1;
    step();
    in_valid = 1'b1; instr = rtype(5'd3, 5'd2, 5'd5, 5'd0, 6'b000111);
    rs_data = 32'h00000026; rt_data = 32'h80000000; exp_icnt++;
    vectors++; if (alu_operation !== 6'b000000 || alu_operandA !== 32'd1 || alu_operandB !== 32'd24) begin miscompares++; $display("FAIL sll_ports: got %b %h %0d want 000000 1 24", alu_operation, alu_operandA, alu_operandB); end
    step();
    in_valid = 1'b0; exp_icnt++;
    vectors++; if (wb_data !== 32'h01000000 || wb_rd !== 5'd4) begin miscompares++; $display("FAIL sll_wb: got %h rd%0d want 01000000 rd4", wb_data, wb_rd); end
    vectors++; if (alu_operation !== 6'b000011 || alu_operandA !== 32'h80000000 || alu_operandB !== 32'd6) begin miscompares++; $display("FAIL srav_ports: got %b %h %0d want 000011 80000000 6", alu_operation, alu_operandA, alu_operandB); end
    step();
    vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'hFE000000 || wb_flags !== 3'b001) begin miscompares++; $display("FAIL srav_wb: got v%b %h f%b want v1 FE000000 f001", wb_valid, wb_data, wb_flags); end
    step();
  endtask

  task automatic test_back_pressure();
    int sent = 0;
    int got = 0;
    int stall_left = -1;
    logic [31:0] hold_data;
    logic [31:0] hold_a;
    logic [5:0]  hold_op;
    logic [31:0] exp_data [4] = '{32'd99, 32'd198, 32'd297, 32'd396};
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (stall_left == -1 && wb_valid) stall_left = 3;
      wb_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      in_valid = (sent < 4);
      instr    = rtype(5'd1, 5'd2, 5'(sent + 1), 5'd0, 6'b100010);
      rs_data  = 32'(100 * (sent + 1));
      rt_data  = 32'(sent + 1);
      #1;
      if (stall_left == 3) begin
        hold_data = wb_data; hold_a = alu_operandA; hold_op = alu_operation;
      end
      if (stall_left > 0) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0 at stall %0d", in_ready, stall_left); end
      end
      if (stall_left > 0 && stall_left < 3) begin
        vectors++; if (wb_data !== hold_data || alu_operandA !== hold_a || alu_operation !== hold_op) begin miscompares++; $display("FAIL bp_hold: got %h %h %b want %h %h %b", wb_data, alu_operandA, alu_operation, hold_data, hold_a, hold_op); end
      end
      if (wb_valid && wb_ready) begin
        vectors++; if (wb_data !== exp_data[got] || wb_rd !== 5'(got + 1)) begin miscompares++; $display("FAIL bp_order%0d: got %0d rd%0d want %0d rd%0d", got, wb_data, wb_rd, exp_data[got], got + 1); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      if (stall_left > 0) stall_left--;
    end
    in_valid = 1'b0; wb_ready = 1'b1; exp_icnt += 4;
    vectors++; if (got !== 4) begin miscompares++; $display("FAIL bp_all_arrived: got %0d want 4", got); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_duplicate: wb_valid got %b want 0", wb_valid); end
    vectors++; if (instr_count !== exp_icnt) begin miscompares++; $display("FAIL bp_count: got %0d want %0d", instr_count, exp_icnt); end
  endtask

  task automatic test_illegal();
    wb_ready = 1'b1;
    in_valid = 1'b1; instr = 32'h20010005; rs_data = 32'hDEAD; rt_data = 32'hBEEF;
    step();
    vectors++; if ({alu_operation, alu_operandA, alu_operandB} !== 70'd0) begin miscompares++; $display("FAIL illegal_e_regs: got %b %h %h want 0", alu_operation, alu_operandA, alu_operandB); end
    instr = rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'b011011);
    step();
    vectors++; if (wb_valid !== 1'b1 || wb_illegal !== 1'b1 || wb_we !== 1'b0 || wb_data !== 32'd0 || wb_flags !== 3'd0) begin miscompares++; $display("FAIL illegal_op: got v%b ill%b we%b %h f%b want v1 ill1 we0 0 f000", wb_valid, wb_illegal, wb_we, wb_data, wb_flags); end
    instr = rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'b101010); rs_data = 32'hFFFFFFFF; rt_data = 32'd1;
    step();
    in_valid = 1'b0; exp_icnt += 3;
    vectors++; if (wb_valid !== 1'b1 || wb_illegal !== 1'b1 || wb_we !== 1'b0 || wb_data !== 32'd0) begin miscompares++; $display("FAIL illegal_funct: got v%b ill%b we%b %h want v1 ill1 we0 0", wb_valid, wb_illegal, wb_we, wb_data); end
    step();
    vectors++; if (wb_illegal !== 1'b0 || wb_data !== 32'd1 || wb_we !== 1'b1 || wb_rd !== 5'd7) begin miscompares++; $display("FAIL slt_after_illegal: got ill%b %h we%b rd%0d want ill0 1 we1 rd7", wb_illegal, wb_data, wb_we, wb_rd); end
    vectors++; if (illegal_count !== 16'd2) begin miscompares++; $display("FAIL illegal_count: got %0d want 2", illegal_count); end
    step();
  endtask

  task automatic test_rd_zero();
    wb_ready = 1'b1; in_valid = 1'b1;
    instr = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'b100101);
    rs_data = 32'hF0F0F0F0; rt_data = 32'h0F0F0F0F;
    step();
    in_valid = 1'b0; exp_icnt++;
    step();
    vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFFFFFF || wb_we !== 1'b0 || wb_flags !== 3'b001) begin miscompares++; $display("FAIL rd_zero: got v%b %h we%b f%b want v1 FFFFFFFF we0 f001", wb_valid, wb_data, wb_we, wb_flags); end
    step();
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b1; in_valid = 1'b1;
    instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000); rs_data = 32'd1; rt_data = 32'd2;
    step();
    instr = rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'b100000);
    step();
    vectors++; if (wb_valid !== 1'b1 || instr_count !== exp_icnt + 2) begin miscompares++; $display("FAIL pre_reset_full: got v%b cnt%0d want v1 cnt%0d", wb_valid, instr_count, exp_icnt + 2); end
    in_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; exp_icnt = 0;
    #1;
    vectors++; if (wb_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset_flags: got v%b r%b want v0 r0", wb_valid, in_ready); end
    vectors++; if (instr_count !== 32'd0 || illegal_count !== 16'd0) begin miscompares++; $display("FAIL mid_reset_counts: got %0d/%0d want 0/0", instr_count, illegal_count); end
    step();
    vectors++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_ready: got r%b v%b want r1 v0", in_ready, wb_valid); end
    in_valid = 1'b1; instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000);
    rs_data = 32'd20; rt_data = 32'd22;
    step();
    in_valid = 1'b0; exp_icnt++;
    step();
    vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'd42 || wb_rd !== 5'd3 || wb_we !== 1'b1) begin miscompares++; $display("FAIL fresh_add: got v%b %0d rd%0d we%b want v1 42 rd3 we1", wb_valid, wb_data, wb_rd, wb_we); end
    vectors++; if (instr_count !== exp_icnt) begin miscompares++; $display("FAIL fresh_count: got %0d want %0d", instr_count, exp_icnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_shift();
    test_back_pressure();
    test_illegal();
    test_rd_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
